uc: RTL and testbench
=====================

# uc

Multicycle control unit for the 8-bit processor; sits directly upstream of the datapath and drives all of its control inputs. Each instruction takes two cycles: FETCH, while the synchronous program memory registers the word at the current PC, then EXEC, where the opcode is decoded and the register-file, flag, port and PC writes fire. Adds a PC enable and a halt state so the datapath's PC register only advances in EXEC.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instruction bits [15:10] from the datapath; valid only in EXEC.
- z  in  1  registered zero flag from the datapath.
- s_inc  out  1  PC mux select: 1 = PC+1, 0 = jump target instr[9:0].
- pc_en  out  1  PC register load enable; the datapath gates its PC register with it.
- we3  out  1  register-file write enable.
- wez  out  1  zero-flag write enable.
- s_we_port  out  1  output-port write enable.
- op_alu  out  3  ALU operation.
- sel_inputs  out  2  WD3 source: 00 ALU, 01 ports, 10 stack, 11 immediate.
- halted  out  1  high while in HALT.

## Operation
- Decode uses opcode[5:2] (instr[15:12]) as the class and the full 6 bits for jumps:
  - 0ooo: ALU op. op_alu = opcode[4:2], we3=1, wez=1, sel_inputs=00.
  - 1000: LDI. we3=1, sel_inputs=11.
  - 1001: IN. we3=1, sel_inputs=01.
  - 1010: OUT. s_we_port=1.
  - 1011: NOP.
  - 110000: JMP. s_inc=0.
  - 110001: JZ. s_inc = ~z.
  - 110010: JNZ. s_inc = z.
  - 111111: HALT.
  - Any other 11xxxx: NOP.
- State machine: FETCH → EXEC → FETCH. EXEC with HALT goes to HALT. HALT is left only by reset.
- FETCH and HALT: pc_en=0, we3=0, wez=0, s_we_port=0, s_inc=1, op_alu=000, sel_inputs=00.
- EXEC: pc_en=1 for every instruction except HALT. Decode outputs apply for exactly this one cycle.
- Outputs are combinational from the state register and opcode/z (Moore/Mealy mix). Only the state is registered.
- Reset value of every output: as in FETCH. halted=0. State = FETCH.

## Timing
- Reset released at edge E0. The memory registers instr[0] at E0+1, which is the end of FETCH. EXEC follows in the next cycle, and the PC loads at the end of EXEC.
- Steady state is 2 cycles per instruction. A taken jump costs no extra cycle.
- z is sampled in the EXEC cycle. An ALU op that writes z at the end of its EXEC is seen by a JZ in the immediately following instruction's EXEC.
- Reset asserted in any state, including mid-EXEC: no write enables are high in the cycle after the reset edge, and the state is FETCH.
- In HALT, all enables stay low indefinitely and the PC holds.

## Configuration
- UC_HALT_EN defined: opcode 111111 enters HALT as described, and halted is driven from state.
- UC_HALT_EN undefined: 111111 decodes as NOP (pc_en=1, s_inc=1), the HALT state is absent, and halted is tied to 0.

## Structure
- Shared package holds:
  - state enum (FETCH, EXEC, HALT);
  - opcode class constants (OP_LDI, OP_IN, OP_OUT, OP_JMP, OP_JZ, OP_JNZ, OP_HALT);
  - sel_inputs encodings (SEL_ALU, SEL_PORT, SEL_STACK, SEL_INM).
- One natural sub-module: uc_decode, the purely combinational opcode/z → control-word decoder. uc wraps it with the state register and the FETCH/HALT masking.

## Test plan
- Reset held 3 cycles then released → cycle 1 FETCH, all enables 0; cycle 2 EXEC. pc_en then pulses high every second cycle.
- opcode=000110 (ALU op 001) in EXEC → we3=1, wez=1, op_alu=001, sel_inputs=00, pc_en=1 for one cycle. All of these are 0 in the next FETCH.
- JZ (110001) with z=1 → s_inc=0, pc_en=1. Same with z=0 → s_inc=1. JNZ (110010) with z=0 → s_inc=0.
- LDI (100000) → we3=1, sel_inputs=11. OUT (101000) → s_we_port=1, we3=0. IN (100100) → we3=1, sel_inputs=01.
- HALT (111111), UC_HALT_EN defined → halted=1 from the next cycle and pc_en=0 for 20 cycles. Reset → FETCH, halted=0. With the macro undefined → treated as NOP.
- Reset asserted during an EXEC of LDI → the following cycle has we3=0 and the state is FETCH.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared types and encodings for the uc control unit.
// Optional HALT support is enabled with UC_HALT_EN.
package uc_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'b1000;
  localparam logic [3:0] OP_IN   = 4'b1001;
  localparam logic [3:0] OP_OUT  = 4'b1010;
  localparam logic [5:0] OP_JMP  = 6'b110000;
  localparam logic [5:0] OP_JZ   = 6'b110001;
  localparam logic [5:0] OP_JNZ  = 6'b110010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [1:0] SEL_ALU   = 2'b00;
  localparam logic [1:0] SEL_PORT  = 2'b01;
  localparam logic [1:0] SEL_STACK = 2'b10;
  localparam logic [1:0] SEL_INM   = 2'b11;

  typedef struct packed {
    logic       pc_en;
    logic       s_inc;
    logic       we3;
    logic       wez;
    logic       s_we_port;
    logic [2:0] op_alu;
    logic [1:0] sel_inputs;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    pc_en:      1'b0,
    s_inc:      1'b1,
    we3:        1'b0,
    wez:        1'b0,
    s_we_port:  1'b0,
    op_alu:     3'b000,
    sel_inputs: SEL_ALU
  };

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode/z to EXEC control-word decoder.
// HALT opcode recognised only when UC_HALT_EN is defined.
module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       z,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl       = CTRL_IDLE;
    ctrl.pc_en = 1'b1;
    unique case (1'b1)
      !opcode[5]: begin
        ctrl.op_alu = opcode[4:2];
        ctrl.we3    = 1'b1;
        ctrl.wez    = 1'b1;
      end
      opcode[5:2] == OP_LDI: begin
        ctrl.we3        = 1'b1;
        ctrl.sel_inputs = SEL_INM;
      end
      opcode[5:2] == OP_IN: begin
        ctrl.we3        = 1'b1;
        ctrl.sel_inputs = SEL_PORT;
      end
      opcode[5:2] == OP_OUT: ctrl.s_we_port = 1'b1;
      opcode == OP_JMP: ctrl.s_inc = 1'b0;
      opcode == OP_JZ:  ctrl.s_inc = ~z;
      opcode == OP_JNZ: ctrl.s_inc = z;
`ifdef UC_HALT_EN
      opcode == OP_HALT: ctrl.pc_en = 1'b0;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/uc.sv
// Two-cycle FETCH/EXEC control unit with optional HALT state.
// HALT state is built only when UC_HALT_EN is defined.
module uc
  import uc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       z,
  output logic       s_inc,
  output logic       pc_en,
  output logic       we3,
  output logic       wez,
  output logic       s_we_port,
  output logic [2:0] op_alu,
  output logic [1:0] sel_inputs,
  output logic       halted
);

  state_t state;
  ctrl_t  dec;
  ctrl_t  ctrl;

  uc_decode u_decode (
    .opcode (opcode),
    .z      (z),
    .ctrl   (dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      unique case (state)
        FETCH: state <= EXEC;
`ifdef UC_HALT_EN
        EXEC:  state <= dec.pc_en ? FETCH : HALT;
`else
        EXEC:  state <= FETCH;
`endif
        HALT:  state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Decoded word only reaches the datapath during EXEC.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (state == EXEC) ctrl = dec;
  end

  assign pc_en      = ctrl.pc_en;
  assign s_inc      = ctrl.s_inc;
  assign we3        = ctrl.we3;
  assign wez        = ctrl.wez;
  assign s_we_port  = ctrl.s_we_port;
  assign op_alu     = ctrl.op_alu;
  assign sel_inputs = ctrl.sel_inputs;

`ifdef UC_HALT_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_uc.sv
// Randomised self-checking bench for uc against a cycle-phase model.
// Follows UC_HALT_EN the same way the design does.
module tb_uc;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       z;
  logic       s_inc, pc_en, we3, wez, s_we_port, halted;
  logic [2:0] op_alu;
  logic [1:0] sel_inputs;

  int checks = 0;
  int failures = 0;

  bit m_valid = 0;
  bit m_exec = 0;
  bit m_halted = 0;

`ifdef UC_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  uc dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .z          (z),
    .s_inc      (s_inc),
    .pc_en      (pc_en),
    .we3        (we3),
    .wez        (wez),
    .s_we_port  (s_we_port),
    .op_alu     (op_alu),
    .sel_inputs (sel_inputs),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [10:0] got,
                       input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b (pc_en,s_inc,we3,wez,port,alu,sel,halted)",
               tag, got, exp);
    end
  endtask

  // Expected outputs from the instruction table, as plain integer rules.
  function automatic logic [10:0] expect_out(int op, bit zz, bit ex, bit hl);
    bit       p_en, inc, w3, wz, port;
    int       alu, sel;
    p_en = 0; inc = 1; w3 = 0; wz = 0; port = 0; alu = 0; sel = 0;
    if (ex) begin
      p_en = 1;
      if (op < 32) begin
        alu = (op / 4) % 8; w3 = 1; wz = 1;
      end else if (op / 4 == 8) begin
        w3 = 1; sel = 3;
      end else if (op / 4 == 9) begin
        w3 = 1; sel = 1;
      end else if (op / 4 == 10) begin
        port = 1;
      end else if (op == 48) begin
        inc = 0;
      end else if (op == 49) begin
        inc = !zz;
      end else if (op == 50) begin
        inc = zz;
      end else if (op == 63 && HALT_EN) begin
        p_en = 0;
      end
    end
    return {p_en, inc, w3, wz, port, alu[2:0], sel[1:0], hl};
  endfunction

  task automatic step(input string tag, input bit rst,
                      input int op, input bit zz);
    @(negedge clk);
    reset  = rst;
    opcode = op[5:0];
    z      = zz;
    #1;
    if (m_valid)
      check(tag,
            {pc_en, s_inc, we3, wez, s_we_port, op_alu, sel_inputs, halted},
            expect_out(op, zz, m_exec, m_halted));
    @(posedge clk);
    if (rst) begin
      m_exec = 0; m_halted = 0;
    end else if (!m_halted) begin
      if (m_exec) begin
        m_exec = 0;
        m_halted = (op == 63) && HALT_EN;
      end else begin
        m_exec = 1;
      end
    end
    m_valid = 1;
  endtask

  // One instruction: a FETCH cycle then its EXEC cycle.
  task automatic instr(input string tag, input int op, input bit zz);
    step({tag, "_f"}, 0, op, zz);
    step({tag, "_x"}, 0, op, zz);
  endtask

  initial begin
    reset = 1; opcode = 0; z = 0;
    for (int i = 0; i < 3; i++) step("reset", 1, 6'h2a, 0);

    instr("alu001", 6'b000110, 0);
    instr("ldi",    6'b100000, 0);
    instr("out",    6'b101000, 1);
    instr("in",     6'b100100, 0);
    instr("jz_t",   6'b110001, 1);
    instr("jz_n",   6'b110001, 0);
    instr("jnz_t",  6'b110010, 0);
    instr("jnz_n",  6'b110010, 1);
    instr("jmp",    6'b110000, 1);
    instr("nop11",  6'b110111, 0);
    instr("nop",    6'b101101, 1);

    step("ldi_f", 0, 6'b100000, 0);
    step("ldi_rx", 1, 6'b100000, 0);
    step("post_rst", 0, 6'b100000, 0);
    step("post_rst2", 0, 6'b100000, 0);

    instr("halt", 6'b111111, 0);
    for (int i = 0; i < 20; i++) step("halt_hold", 0, $urandom_range(0, 63), 1);
    step("halt_rst", 1, 0, 0);
    instr("after", 6'b000110, 0);

    for (int i = 0; i < 3000; i++) begin
      int op;
      bit rst;
      op  = $urandom_range(0, 63);
      rst = ($urandom_range(0, 39) == 0) || (m_halted && $urandom_range(0, 7) == 0);
      step("rand", rst, op, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
